ternary_lane_sequencer: RTL and testbench

- Job-level controller for an array of LANES ternary lane ALUs (accumulate-multiply PEs).
- Accepts one job command: trit count plus 32-bit exec hints.
- Clears the lane accumulators, then streams packed weight/input trits into the lanes under a valid/ready handshake.
- Waits one drain cycle, then serialises each lane's accumulator and overflow flag onto a result stream. Sits between the DMA/stream fabric and the lane array.

---
 rtl/tfab_pkg.sv | 28 ++
 rtl/ternary_result_mux.sv | 39 +++
 rtl/ternary_lane_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_ternary_lane_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tfab_pkg.sv
// Shared definitions for the ternary lane fabric: trit encodings, op_mode codes
// and the sequencer state type.
package tfab_pkg;

  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b10;

  localparam logic [7:0] OP_DOT   = 8'h01;
  localparam logic [7:0] OP_MUL   = 8'h03;
  localparam logic [7:0] OP_TCONV = 8'h04;
  localparam logic [7:0] OP_TPOOL = 8'h05;
  localparam logic [7:0] OP_TGEMM = 8'h06;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_DRAIN,
    ST_READOUT
  } seq_state_t;

  function automatic logic op_legal(input logic [7:0] op);
    return (op == OP_DOT) || (op == OP_MUL) || (op == OP_TCONV) ||
           (op == OP_TPOOL) || (op == OP_TGEMM);
  endfunction

endpackage

// File: rtl/ternary_result_mux.sv
// Selects one lane's accumulator and overflow flag and holds it in a register
// until the sequencer asks for the next lane.
module ternary_result_mux
  import tfab_pkg::*;
#(
  parameter int LANES = 4,
  parameter int IDX_W = 4
) (
  input  logic                  clk,
  input  logic                  load,
  input  logic [IDX_W-1:0]      sel,
  input  logic [32*LANES-1:0]   lane_acc,
  input  logic [LANES-1:0]      lane_ovf,
  output logic [31:0]           data,
  output logic                  ovf
);

  logic [31:0] pick_data;
  logic        pick_ovf;

  always_comb begin
    pick_data = '0;
    pick_ovf  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (sel == IDX_W'(i)) begin
        pick_data = lane_acc[32*i +: 32];
        pick_ovf  = lane_ovf[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      data <= pick_data;
      ovf  <= pick_ovf;
    end
  end

endmodule

// File: rtl/ternary_lane_sequencer.sv
// Job-level controller for the ternary lane array: clears the lanes, streams
// trit beats into them, lets them settle, then serialises their results.
module ternary_lane_sequencer
  import tfab_pkg::*;
#(
  parameter int LANES = 4,
  parameter int LEN_W = 16,
  parameter int IDX_W = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic [31:0]           cmd_hints,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [2*LANES-1:0]    s_weight,
  input  logic [2*LANES-1:0]    s_trit,
  output logic                  lane_clear,
  output logic                  lane_enable,
  output logic [2*LANES-1:0]    lane_weight,
  output logic [2*LANES-1:0]    lane_trit,
  output logic [31:0]           lane_hints,
  input  logic [32*LANES-1:0]   lane_acc,
  input  logic [LANES-1:0]      lane_ovf,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [31:0]           r_data,
  output logic [IDX_W-1:0]      r_idx,
  output logic                  r_ovf,
  output logic                  r_last,
  output logic                  busy,
  output logic                  done,
  output logic                  cmd_err,
  output logic                  illegal_trit
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  seq_state_t       state;
  logic [LEN_W-1:0] rem;
  logic [IDX_W-1:0] idx;
  logic             drain_wait;
  logic             mux_load;
  logic [IDX_W-1:0] mux_sel;
  logic             beat_ok;
  logic             r_hs;

  // Unused encoding 2'b11 is forwarded to the lanes as a zero trit.
  function automatic logic [2*LANES-1:0] clean_trits(input logic [2*LANES-1:0] v);
    logic [2*LANES-1:0] o;
    o = v;
    for (int i = 0; i < LANES; i++) begin
      case (v[2*i +: 2])
        TRIT_ZERO, TRIT_POS, TRIT_NEG: o[2*i +: 2] = v[2*i +: 2];
        default:                       o[2*i +: 2] = TRIT_ZERO;
      endcase
    end
    return o;
  endfunction

  function automatic logic has_bad_trit(input logic [2*LANES-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < LANES; i++)
      if (v[2*i +: 2] == 2'b11) bad = 1'b1;
    return bad;
  endfunction

  assign beat_ok = s_valid && s_ready;
  assign r_hs    = r_valid && r_ready;
  assign r_idx   = idx;

  // The hold register captures lane 0 on the last drain cycle, then the next
  // lane on every non-final result handshake.
  always_comb begin
    mux_load = 1'b0;
    mux_sel  = idx;
    if (state == ST_DRAIN && drain_wait) begin
      mux_load = 1'b1;
      mux_sel  = '0;
    end else if (state == ST_READOUT && r_hs && idx != LAST_IDX) begin
      mux_load = 1'b1;
      mux_sel  = idx + 1'b1;
    end
  end

  ternary_result_mux #(.LANES(LANES), .IDX_W(IDX_W)) u_result_mux (
    .clk      (clk),
    .load     (mux_load),
    .sel      (mux_sel),
    .lane_acc (lane_acc),
    .lane_ovf (lane_ovf),
    .data     (r_data),
    .ovf      (r_ovf)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cmd_ready    <= 1'b1;
      s_ready      <= 1'b0;
      lane_clear   <= 1'b1;
      lane_enable  <= 1'b0;
      lane_weight  <= '0;
      lane_trit    <= '0;
      lane_hints   <= '0;
      r_valid      <= 1'b0;
      r_last       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cmd_err      <= 1'b0;
      illegal_trit <= 1'b0;
      rem          <= '0;
      idx          <= '0;
      drain_wait   <= 1'b0;
    end else begin
      done        <= 1'b0;
      lane_clear  <= 1'b0;
      lane_enable <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (!op_legal(cmd_hints[7:0])) begin
              cmd_err <= 1'b1;
              done    <= 1'b1;
            end else begin
              cmd_err    <= 1'b0;
              rem        <= cmd_len;
              lane_hints <= cmd_hints;
              lane_clear <= 1'b1;
              cmd_ready  <= 1'b0;
              busy       <= 1'b1;
              state      <= ST_CLEAR;
            end
          end
        end
        ST_CLEAR: begin
          drain_wait <= 1'b0;
          if (rem == '0) begin
            state <= ST_DRAIN;
          end else begin
            s_ready <= 1'b1;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (beat_ok) begin
            lane_enable <= 1'b1;
            lane_weight <= clean_trits(s_weight);
            lane_trit   <= clean_trits(s_trit);
            if (has_bad_trit(s_weight) || has_bad_trit(s_trit)) illegal_trit <= 1'b1;
            rem <= rem - 1'b1;
            if (rem == LEN_W'(1)) begin
              s_ready    <= 1'b0;
              drain_wait <= 1'b0;
              state      <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!drain_wait) begin
            drain_wait <= 1'b1;
          end else begin
            drain_wait <= 1'b0;
            idx        <= '0;
            r_valid    <= 1'b1;
            r_last     <= (LANES == 1);
            state      <= ST_READOUT;
          end
        end
        ST_READOUT: begin
          if (r_hs) begin
            if (idx == LAST_IDX) begin
              r_valid   <= 1'b0;
              r_last    <= 1'b0;
              idx       <= '0;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
              done      <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              idx    <= idx + 1'b1;
              r_last <= ((idx + 1'b1) == LAST_IDX);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_lane_sequencer.sv
// Randomised scoreboard bench for ternary_lane_sequencer with a stand-in lane
// array whose overflow flag trips once a running sum leaves +/-OVF_LIM.
module tb_ternary_lane_sequencer;
  import tfab_pkg::*;

  localparam int LANES   = 4;
  localparam int LEN_W   = 16;
  localparam int IDX_W   = 4;
  localparam int OVF_LIM = 5;

  logic                 clk;
  logic                 reset_n;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [LEN_W-1:0]     cmd_len;
  logic [31:0]          cmd_hints;
  logic                 s_valid;
  logic                 s_ready;
  logic [2*LANES-1:0]   s_weight;
  logic [2*LANES-1:0]   s_trit;
  logic                 lane_clear;
  logic                 lane_enable;
  logic [2*LANES-1:0]   lane_weight;
  logic [2*LANES-1:0]   lane_trit;
  logic [31:0]          lane_hints;
  logic [32*LANES-1:0]  lane_acc;
  logic [LANES-1:0]     lane_ovf;
  logic                 r_valid;
  logic                 r_ready;
  logic [31:0]          r_data;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_ovf;
  logic                 r_last;
  logic                 busy;
  logic                 done;
  logic                 cmd_err;
  logic                 illegal_trit;

  typedef struct {
    logic [31:0]      data;
    logic             ovf;
    logic [IDX_W-1:0] idx;
    logic             last;
  } res_t;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   enable_cnt = 0;
  int   clear_cnt = 0;
  int   rr_mode = 0;
  bit   expect_done = 1'b0;
  int   acc_m[LANES];
  bit   ovf_m[LANES];

  ternary_lane_sequencer #(.LANES(LANES), .LEN_W(LEN_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .cmd_hints(cmd_hints), .s_valid(s_valid), .s_ready(s_ready),
    .s_weight(s_weight), .s_trit(s_trit), .lane_clear(lane_clear),
    .lane_enable(lane_enable), .lane_weight(lane_weight), .lane_trit(lane_trit),
    .lane_hints(lane_hints), .lane_acc(lane_acc), .lane_ovf(lane_ovf),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_idx(r_idx),
    .r_ovf(r_ovf), .r_last(r_last), .busy(busy), .done(done), .cmd_err(cmd_err),
    .illegal_trit(illegal_trit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int tval(input logic [1:0] c);
    case (c)
      TRIT_POS: return 1;
      TRIT_NEG: return -1;
      default:  return 0;
    endcase
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stand-in lane array driven by the sequencer's lane bus.
  always @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (lane_clear === 1'b1) begin
        acc_m[i] <= 0;
        ovf_m[i] <= 1'b0;
      end else if (lane_enable === 1'b1) begin
        acc_m[i] <= acc_m[i] + tval(lane_weight[2*i +: 2]) * tval(lane_trit[2*i +: 2]);
        ovf_m[i] <= ovf_m[i] | (iabs(acc_m[i] + tval(lane_weight[2*i +: 2]) *
                                     tval(lane_trit[2*i +: 2])) > OVF_LIM);
      end
    end
  end

  always_comb begin
    lane_acc = '0;
    lane_ovf = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_acc[32*i +: 32] = acc_m[i];
      lane_ovf[i]          = ovf_m[i];
    end
  end

  // Result consumer: always ready, random, or held off.
  initial begin
    r_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       r_ready = 1'b1;
        1:       r_ready = ($urandom_range(0, 99) < 60);
        default: r_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares every presented result against the scoreboard head.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (lane_enable === 1'b1) enable_cnt++;
      if (lane_clear === 1'b1 && reset_n === 1'b1) clear_cnt++;
      if (expect_done) begin
        check("done_after_last", {63'd0, done}, 64'd1);
        expect_done = 1'b0;
      end
      if (r_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("no_result_expected", {63'd0, r_valid}, 64'd0);
        end else begin
          e = exp_q[0];
          check("result", {r_data, r_ovf, r_idx, r_last}, {e.data, e.ovf, e.idx, e.last});
          if (r_ready === 1'b1) begin
            void'(exp_q.pop_front());
            if (r_last === 1'b1) expect_done = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] pick_trit();
    int c;
    c = $urandom_range(0, 2);
    return (c == 0) ? TRIT_ZERO : (c == 1) ? TRIT_POS : TRIT_NEG;
  endfunction

  task automatic send_cmd(input int len, input logic [31:0] hints);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (cmd_ready !== 1'b1) check("cmd_ready_timeout", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    cmd_hints = hints;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drive_beat(input logic [2*LANES-1:0] w, input logic [2*LANES-1:0] t);
    bit ok;
    int n;
    s_valid  = 1'b1;
    s_weight = w;
    s_trit   = t;
    n = 0;
    do begin
      ok = (s_ready === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 300);
    if (!ok) check("beat_accept_timeout", {63'd0, s_ready}, 64'd1);
    s_valid = 1'b0;
  endtask

  task automatic run_job(input int len, input logic [7:0] op, input int gap_max,
                         input bit fixed_gaps, input bit ones, input bit bad_trit);
    logic [2*LANES-1:0] wv[16];
    logic [2*LANES-1:0] tv[16];
    int    s[LANES];
    bit    o[LANES];
    int    gaps[3] = '{0, 2, 1};
    int    gap;
    int    n;
    logic [31:0] hi;
    res_t  e;
    for (int b = 0; b < len; b++) begin
      for (int i = 0; i < LANES; i++) begin
        wv[b][2*i +: 2] = ones ? TRIT_POS : pick_trit();
        tv[b][2*i +: 2] = ones ? TRIT_POS : pick_trit();
      end
      if (bad_trit && b == 0) tv[b][5:4] = 2'b11;
    end
    for (int i = 0; i < LANES; i++) begin
      s[i] = 0;
      o[i] = 1'b0;
      for (int b = 0; b < len; b++) begin
        s[i] += tval(wv[b][2*i +: 2]) * tval(tv[b][2*i +: 2]);
        if (iabs(s[i]) > OVF_LIM) o[i] = 1'b1;
      end
      e.data = s[i];
      e.ovf  = o[i];
      e.idx  = IDX_W'(i);
      e.last = (i == LANES - 1);
      exp_q.push_back(e);
    end
    enable_cnt = 0;
    clear_cnt  = 0;
    hi = $urandom();
    send_cmd(len, {hi[23:0], op});
    check("clear_on_accept", {63'd0, lane_clear}, 64'd1);
    check("cmd_err_cleared", {63'd0, cmd_err}, 64'd0);
    check("busy_on_accept", {63'd0, busy}, 64'd1);
    check("hints_latched", {32'd0, lane_hints}, {32'd0, hi[23:0], op});
    for (int b = 0; b < len; b++) begin
      gap = fixed_gaps ? gaps[b % 3] : $urandom_range(0, gap_max);
      repeat (gap) begin
        s_valid  = 1'b0;
        s_weight = 8'($urandom());
        s_trit   = 8'($urandom());
        @(posedge clk);
        #1;
      end
      drive_beat(wv[b], tv[b]);
      if (bad_trit && b == 0) begin
        check("bad_beat_enable", {63'd0, lane_enable}, 64'd1);
        check("bad_trit_zeroed", {62'd0, lane_trit[5:4]}, 64'd0);
        check("illegal_trit_set", {63'd0, illegal_trit}, 64'd1);
      end
    end
    n = 0;
    while (done !== 1'b1 && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done !== 1'b1) check("job_done_timeout", {63'd0, done}, 64'd1);
    check("enable_cycles", 64'(enable_cnt), 64'(len));
    check("clear_cycles", 64'(clear_cnt), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic illegal_cmd(input logic [7:0] op);
    clear_cnt = 0;
    send_cmd(3, {24'h0, op});
    check("illegal_done", {63'd0, done}, 64'd1);
    check("illegal_cmd_err", {63'd0, cmd_err}, 64'd1);
    check("illegal_not_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    check("illegal_done_pulse", {63'd0, done}, 64'd0);
    check("cmd_err_sticky", {63'd0, cmd_err}, 64'd1);
    repeat (4) @(posedge clk);
    #1;
    check("illegal_no_clear", 64'(clear_cnt), 64'd0);
  endtask

  initial begin
    logic [7:0] legal_ops[5] = '{OP_DOT, OP_MUL, OP_TCONV, OP_TPOOL, OP_TGEMM};
    cmd_valid = 1'b0;
    cmd_len   = '0;
    cmd_hints = '0;
    s_valid   = 1'b0;
    s_weight  = '0;
    s_trit    = '0;
    reset_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_lane_clear", {63'd0, lane_clear}, 64'd1);
    check("rst_lane_enable", {63'd0, lane_enable}, 64'd0);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_flags", {60'd0, r_valid, done, cmd_err, illegal_trit}, 64'd0);
    check("rst_lane_bus", {16'd0, lane_weight, lane_trit, lane_hints}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_clear_low", {63'd0, lane_clear}, 64'd0);

    // Legal DOT job of all +1 products, then the same job with stalls.
    rr_mode = 0;
    run_job(3, OP_DOT, 0, 1'b0, 1'b1, 1'b0);
    rr_mode = 2;
    fork
      run_job(3, OP_DOT, 0, 1'b1, 1'b1, 1'b0);
      begin
        int n;
        n = 0;
        while (r_valid !== 1'b1 && n < 300) begin
          @(posedge clk);
          #1;
          n++;
        end
        repeat (5) @(posedge clk);
        #1;
        rr_mode = 0;
      end
    join

    run_job(0, OP_TCONV, 0, 1'b0, 1'b0, 1'b0);

    illegal_cmd(8'h02);
    run_job(2, OP_MUL, 1, 1'b0, 1'b0, 1'b0);

    run_job(3, OP_TPOOL, 1, 1'b0, 1'b0, 1'b1);
    run_job(2, OP_DOT, 1, 1'b0, 1'b0, 1'b0);
    check("illegal_trit_sticky", {63'd0, illegal_trit}, 64'd1);

    // Reset in the middle of a run after two of five beats.
    send_cmd(5, {24'h0, OP_TGEMM});
    for (int b = 0; b < 2; b++) drive_beat(8'($urandom()), 8'($urandom()));
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_lane_clear", {63'd0, lane_clear}, 64'd1);
    check("midrst_ctrl", {59'd0, lane_enable, busy, s_ready, r_valid, done}, 64'd0);
    check("midrst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("midrst_flags", {62'd0, cmd_err, illegal_trit}, 64'd0);
    check("midrst_lane_bus", {16'd0, lane_weight, lane_trit, lane_hints}, 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_clear_low", {63'd0, lane_clear}, 64'd0);
    run_job(1, OP_DOT, 0, 1'b0, 1'b0, 1'b0);

    rr_mode = 1;
    for (int j = 0; j < 24; j++) begin
      if (j % 6 == 5) illegal_cmd((j % 12 == 5) ? 8'h00 : 8'hFF);
      run_job($urandom_range(0, 12), legal_ops[$urandom_range(0, 4)], 2, 1'b0, 1'b0, 1'b0);
    end
    rr_mode = 0;
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
